// File: rtl/mod_exp_iter_if.sv
// Start/result bus of the modular exponentiator.
// master = requester (drives operands), slave = engine.
interface mod_exp_iter_if #(
    parameter int WIDTH     = 64,
    parameter int EXP_WIDTH = 64
);
    logic                 start;
    logic                 ready;
    logic [WIDTH-1:0]     base;
    logic [WIDTH-1:0]     modulo;
    logic [EXP_WIDTH-1:0] exponent;
    logic                 const_time;
    logic                 result_valid;
    logic [WIDTH-1:0]     result;
    logic                 error;

    modport master (
        output start, base, modulo, exponent, const_time,
        input  ready, result_valid, result, error
    );

    modport slave (
        input  start, base, modulo, exponent, const_time,
        output ready, result_valid, result, error
    );
endinterface

// File: rtl/mod_exp_iter.sv
// Iterative right-to-left binary modular exponentiator.
// Base is pre-reduced bit-serially; each exponent bit runs two bit-serial
// interleaved modular multipliers (result*base and base*base) in parallel.
module mod_exp_iter #(
    parameter int WIDTH     = 64,
    parameter int EXP_WIDTH = 64
) (
    input logic           clk,
    input logic           rst_n,
    mod_exp_iter_if.slave bus
);
    // LOAD is the cycle right after accept, where captured operands are inspected.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_REDUCE = 3'd2;
    localparam logic [2:0] S_STEP   = 3'd3;
    localparam logic [2:0] S_MUL    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = $clog2(EXP_WIDTH + 1);
    localparam int AW = WIDTH + 2;  // 2*acc + B < 3n fits here

    logic [2:0]           state_q, state_d;
    logic [WIDTH-1:0]     base_q, mod_q, res_q, a1_q, a2_q, result_q;
    logic [EXP_WIDTH-1:0] exp_q;
    logic                 ct_q, error_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bits_q;
    // m1_acc_q keeps the final M1 product, so it also serves as the sink
    // for the dummy multiply when the exponent bit is clear.
    logic [AW-1:0]        red_acc_q, m1_acc_q, m2_acc_q;

    logic [AW-1:0]        n_ext, b_ext, red_next, m1_next, m2_next;
    logic                 accept, last, no_bits;

    // One interleaved step: acc = 2*acc + (abit ? B : 0), then bring back below n.
    function automatic logic [AW-1:0] mul_step(input logic [AW-1:0] acc,
                                                input logic          abit,
                                                input logic [AW-1:0] b,
                                                input logic [AW-1:0] n);
        logic [AW-1:0] t;
        t = (acc << 1) + (abit ? b : '0);
        if (t >= n) t = t - n;
        if (t >= n) t = t - n;
        return t;
    endfunction

    assign accept  = bus.start && (state_q == S_IDLE);
    assign last    = (cnt_q == CW'(WIDTH - 1));
    assign no_bits = ct_q ? (bits_q == BW'(EXP_WIDTH)) : (exp_q == '0);
    assign n_ext   = AW'(mod_q);
    assign b_ext   = AW'(base_q);

    // Datapath step values for reduction and both multipliers.
    always_comb begin
        red_next = (red_acc_q << 1) + AW'(base_q[WIDTH-1]);
        if (red_next >= n_ext) red_next = red_next - n_ext;
        m1_next = mul_step(m1_acc_q, a1_q[WIDTH-1], b_ext, n_ext);
        m2_next = mul_step(m2_acc_q, a2_q[WIDTH-1], b_ext, n_ext);
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_LOAD;
            S_LOAD:   state_d = (mod_q == '0) ? S_DONE : S_REDUCE;
            S_REDUCE: if (last) state_d = S_STEP;
            S_STEP:   state_d = no_bits ? S_DONE : S_MUL;
            S_MUL:    if (last) state_d = S_STEP;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register and per-state datapath updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            mod_q     <= '0;
            res_q     <= '0;
            a1_q      <= '0;
            a2_q      <= '0;
            result_q  <= '0;
            exp_q     <= '0;
            ct_q      <= 1'b0;
            error_q   <= 1'b0;
            cnt_q     <= '0;
            bits_q    <= '0;
            red_acc_q <= '0;
            m1_acc_q  <= '0;
            m2_acc_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (accept) begin
                    base_q  <= bus.base;
                    mod_q   <= bus.modulo;
                    exp_q   <= bus.exponent;
                    ct_q    <= bus.const_time;
                    error_q <= 1'b0;
                end
                S_LOAD: begin
                    if (mod_q == '0) begin
                        error_q  <= 1'b1;
                        result_q <= '0;
                    end else begin
                        red_acc_q <= '0;
                        cnt_q     <= '0;
                        bits_q    <= '0;
                        res_q     <= (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                    end
                end
                S_REDUCE: begin
                    red_acc_q <= red_next;
                    cnt_q     <= cnt_q + CW'(1);
                    base_q    <= last ? red_next[WIDTH-1:0] : (base_q << 1);
                end
                S_STEP: begin
                    if (no_bits) begin
                        result_q <= res_q;
                    end else begin
                        a1_q     <= res_q;
                        a2_q     <= base_q;
                        m1_acc_q <= '0;
                        m2_acc_q <= '0;
                        cnt_q    <= '0;
                    end
                end
                S_MUL: begin
                    a1_q     <= a1_q << 1;
                    a2_q     <= a2_q << 1;
                    m1_acc_q <= m1_next;
                    m2_acc_q <= m2_next;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last) begin
                        base_q <= m2_next[WIDTH-1:0];
                        if (exp_q[0]) res_q <= m1_next[WIDTH-1:0];
                        exp_q  <= exp_q >> 1;
                        bits_q <= bits_q + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready        = (state_q == S_IDLE);
    assign bus.result_valid = (state_q == S_DONE);
    assign bus.result       = result_q;
    assign bus.error        = error_q;
endmodule

// File: doc/mod_exp_iter.md
Name: mod_exp_iter

Overview:
- Parametrised iterative modular exponentiator computing base^exponent mod modulo by right-to-left binary exponentiation.
- Replaces full-width combinational multiply/mod with two bit-serial interleaved modular multipliers.
- Adds a valid/ready start handshake, a constant-time mode and error reporting.
- Sits under the RSA wrapper as the exponentiation engine.

Parameters:
- WIDTH, 64: operand width in bits for base, modulo and result.
- EXP_WIDTH, 64: exponent width in bits; number of bits processed in constant-time mode.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request valid; accepted when start && ready
- ready  out  1  high only in IDLE
- base  in  WIDTH  base a; any value, including values >= modulo
- modulo  in  WIDTH  modulus n
- exponent  in  EXP_WIDTH  exponent b
- const_time  in  1  1 = always process EXP_WIDTH bits and do the dummy multiply on 0 bits
- result_valid  out  1  one-cycle pulse when result/error are final
- result  out  WIDTH  a^b mod n; held until the next accept
- error  out  1  set with result_valid when modulo==0; held until the next accept

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, ready=1, result_valid=0, result=0, error=0, all internal registers 0.
  - Reset mid-operation aborts the operation; no result_valid is produced.
- Accept (start && ready at a rising edge, the "cycle 0" edge):
  - Capture base, modulo, exponent and const_time.
  - Clear error.
  - ready drops the next cycle.
  - start while not ready is ignored.
- States: IDLE, REDUCE, STEP, MUL, DONE.
- IDLE -> DONE if captured modulo==0: error=1, result=0.
- IDLE -> REDUCE otherwise:
  - Base is reduced bit-serially, MSB first, over WIDTH cycles: acc = 2*acc + bit; subtract n once if acc >= n.
  - result_reg is initialised to (n==1 ? 0 : 1).
- REDUCE -> STEP after exactly WIDTH cycles.
- STEP lasts 1 cycle and picks the next state:
  - DONE if there are no bits left.
    - Normal mode: exponent_reg==0.
    - Constant-time mode: bit counter == EXP_WIDTH.
  - MUL otherwise.
- MUL (WIDTH cycles), two interleaved modular multipliers running in parallel:
  - M1 computes result_reg*base_reg mod n.
  - M2 computes base_reg*base_reg mod n.
  - Each cycle: acc = 2*acc + (a_i ? B : 0), then up to two conditional subtracts of n.
  - Internal accumulator width is WIDTH+2 (bound 3n).
  - Invariant: all operands are < n.
- End of MUL (back to STEP):
  - base_reg <= M2.
  - If exponent_reg[0] is set, result_reg <= M1.
  - If the bit is clear, M1 goes to a discard register (const_time=1 always runs M1; const_time=0 may skip it, latency is unchanged).
  - exponent_reg >>= 1, bit counter += 1.
- DONE:
  - result_valid=1 for exactly 1 cycle.
  - result = result_reg.
  - Next cycle goes to IDLE, ready=1.
- Latency: result_valid is high in cycle L = (k+1)*(WIDTH+1)+1 after the accept edge.
  - k = processed bits.
  - Normal mode: k = position of the highest set exponent bit + 1; k=0 when exponent==0.
  - Constant-time mode: k = EXP_WIDTH.
  - modulo==0: L=1.
- Boundary cases:
  - exponent==0 gives result 1 (0 if n==1).
  - n==1 gives 0 for any exponent.
  - base==0 with exponent>0 gives 0.
  - Maximum operands (all ones) must not overflow the accumulator.

Test Plan:
- WIDTH=16, EXP_WIDTH=16, normal mode: base=4, mod=497, exp=13 -> result=445, error=0, L=(4+1)*17+1=86.
- base=2, mod=1000, exp=10 -> result=24; base=10, mod=7, exp=3 -> result=6 (exercises base>mod pre-reduction).
- base=3, mod=7, exp=0 -> result=1, L=18; base=5, mod=1, exp=9 -> result=0.
- mod=0, any base/exp -> error=1, result=0, result_valid at L=1; the next accept clears error.
- const_time=1, base=4, mod=497, exp=13 -> result=445, L=17*17+1=290, identical to the run with exp=0x8000 modulo timing; pulsing start while busy is ignored.
- Assert rst_n low mid-MUL -> ready=1, result=0, no result_valid pulse; a new request then completes correctly.
